// File: rtl/gcd_job_dispatcher_pkg.sv
// Shared definitions for the GCD job dispatcher: controller state encoding,
// operand/cycle-count widths, job record and the saturating counter helper.
package gcd_job_dispatcher_pkg;

  localparam int OPW  = 16;
  localparam int CYCW = 17;
  localparam logic [CYCW-1:0] CYC_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_OUTPUT    = 3'd4
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } job_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [CYCW-1:0] sat_inc(input logic [CYCW-1:0] v);
    if (v == CYC_MAX) begin
      return v;
    end else begin
      return v + 17'd1;
    end
  endfunction

endpackage

// File: rtl/gcd_job_fifo.sv
// Job queue for the GCD dispatcher. Pointers carry one extra wrap bit so that
// full and empty are distinguishable; a push into a full queue is dropped even
// if a pop happens in the same cycle.
module gcd_job_fifo
  import gcd_job_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  job_t push_data,
  input  logic pop,
  output job_t head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  job_t        mem_q [FIFO_DEPTH];
  job_t        mem_d [FIFO_DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_q[rd_ptr_q[PW-1:0]];

  // Next pointer and storage values for accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok_s) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Queue registers; reset empties the queue and clears storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {(PW+1){1'b0}};
      rd_ptr_q <= {(PW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '{a: 16'd0, b: 16'd0};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// GCD job dispatcher: queues {a,b} jobs, issues them one at a time to an
// external GCD engine (start pulse, done held two cycles) and presents each
// result on a valid/ready output. Only one job is ever in flight.
// Optional feature: define GCD_DISP_CYCLE_CNT_EN to add out_cycles, the
// ISSUE-to-first-done cycle count of the job being presented.
module gcd_job_dispatcher
  import gcd_job_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_gcd,
  output logic            eng_start,
  output logic [OPW-1:0]  eng_a,
  output logic [OPW-1:0]  eng_b,
  input  logic            eng_done,
  input  logic [OPW-1:0]  eng_gcd,
`ifdef GCD_DISP_CYCLE_CNT_EN
  output logic [CYCW-1:0] out_cycles,
`endif
  output logic            busy
);

  state_e         state_q, state_d;
  logic           eng_start_q, eng_start_d;
  logic [OPW-1:0] eng_a_q, eng_a_d;
  logic [OPW-1:0] eng_b_q, eng_b_d;
  logic [OPW-1:0] result_q, result_d;
  logic           out_valid_q, out_valid_d;
  logic [OPW-1:0] out_gcd_q, out_gcd_d;
  logic           pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  job_t           head_s;
  job_t           push_job_s;

  assign push_job_s = '{a: in_a, b: in_b};

  gcd_job_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_data(push_job_s),
    .pop      (pop_s),
    .head     (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign in_ready  = !fifo_full_s;
  assign busy      = !fifo_empty_s || (state_q != ST_IDLE);
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = out_gcd_q;

  // Controller next state; engine and output registers are loaded from the
  // next state so the ports come straight from flops.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    eng_start_d = 1'b0;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d     = ST_ISSUE;
          eng_start_d = 1'b1;
          eng_a_d     = head_s.a;
          eng_b_d     = head_s.b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pop_s   = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (eng_done) begin
          result_d = eng_gcd;
          state_d  = ST_RELEASE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RELEASE: begin
        if (eng_done) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_OUTPUT);
    if (state_d == ST_OUTPUT) begin
      out_gcd_d = result_d;
    end else begin
      out_gcd_d = 16'd0;
    end
  end

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      eng_start_q <= 1'b0;
      eng_a_q     <= 16'd0;
      eng_b_q     <= 16'd0;
      result_q    <= 16'd0;
      out_valid_q <= 1'b0;
      out_gcd_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      eng_start_q <= eng_start_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_gcd_q   <= out_gcd_d;
    end
  end

`ifdef GCD_DISP_CYCLE_CNT_EN
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic [CYCW-1:0] out_cycles_q, out_cycles_d;

  assign out_cycles = out_cycles_q;

  // Count the ISSUE cycle plus every WAIT_DONE cycle before done rises.
  always_comb begin
    cyc_d = cyc_q;
    case (state_q)
      ST_ISSUE: begin
        cyc_d = 17'd1;
      end
      ST_WAIT_DONE: begin
        if (!eng_done) begin
          cyc_d = sat_inc(cyc_q);
        end else begin
          cyc_d = cyc_q;
        end
      end
      default: begin
        cyc_d = cyc_q;
      end
    endcase
    if (state_d == ST_OUTPUT) begin
      out_cycles_d = cyc_q;
    end else begin
      out_cycles_d = 17'd0;
    end
  end

  // Cycle counter and its presented copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q        <= 17'd0;
      out_cycles_q <= 17'd0;
    end else begin
      cyc_q        <= cyc_d;
      out_cycles_q <= out_cycles_d;
    end
  end
`else
  // Cycle counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Directed bench for gcd_job_dispatcher with a behavioural Euclid engine
// (start/done protocol, done held two cycles).
module tb_gcd_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_gcd;
  logic        eng_start;
  logic [15:0] eng_a;
  logic [15:0] eng_b;
  logic        eng_done;
  logic [15:0] eng_gcd;
  logic        busy;
`ifdef GCD_DISP_CYCLE_CNT_EN
  logic [16:0] out_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gcd_job_dispatcher #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_gcd  (out_gcd),
    .eng_start(eng_start),
    .eng_a    (eng_a),
    .eng_b    (eng_b),
    .eng_done (eng_done),
    .eng_gcd  (eng_gcd),
`ifdef GCD_DISP_CYCLE_CNT_EN
    .out_cycles(out_cycles),
`endif
    .busy     (busy)
  );

  // Engine model: one Euclid step per cycle, then done for two cycles.
  logic [1:0]  e_st;
  logic [15:0] e_a, e_b, e_res;
  always @(posedge clk) begin
    if (!rst_n) begin
      e_st <= 2'd0; e_a <= 16'd0; e_b <= 16'd0; e_res <= 16'd0;
    end else begin
      case (e_st)
        2'd0: if (eng_start) begin e_a <= eng_a; e_b <= eng_b; e_st <= 2'd1; end
        2'd1: if (e_b == 16'd0) begin e_res <= e_a; e_st <= 2'd2; end
              else begin e_a <= e_b; e_b <= e_a % e_b; end
        2'd2: e_st <= 2'd3;
        default: e_st <= 2'd0;
      endcase
    end
  end
  assign eng_done = (e_st == 2'd2) || (e_st == 2'd3);
  assign eng_gcd  = eng_done ? e_res : 16'd0;

  // Monitors sampled on the falling edge.
  int          n_starts = 0;
  logic [15:0] results[$];
  int          meas_q[$];
  int          meas_cnt = 0;
  bit          meas_run = 1'b0;
  always @(negedge clk) begin
    if (eng_start) n_starts++;
    if (out_valid && out_ready) results.push_back(out_gcd);
    if (eng_start) begin
      meas_cnt = 1; meas_run = 1'b1;
    end else if (meas_run) begin
      if (eng_done) begin meas_run = 1'b0; meas_q.push_back(meas_cnt); end
      else meas_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_out_valid(input string tag);
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) step();
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
    chk(tag, busy, 0);
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 300 && results.size() < n; i++) step();
    chk(tag, results.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    int accepted;
    logic ready6;
    logic [15:0] ja [6];
    logic [15:0] jb [6];
    ja = '{16'd12, 16'd9, 16'd10, 16'd14, 16'd8, 16'd7};
    jb = '{16'd4,  16'd6, 16'd5,  16'd21, 16'd12, 16'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_b", eng_b, 0);
    chk("rst_busy", busy, 0);

    // Single job (48,18) and issue latency.
    s0 = n_starts; results.delete();
    in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
    step();
    in_valid = 1'b0;
    chk("lat_n1_start", eng_start, 0);
    chk("lat_n1_busy", busy, 1);
    step();
    chk("lat_n2_start", eng_start, 1);
    chk("issue_eng_a", eng_a, 48);
    chk("issue_eng_b", eng_b, 18);
    step();
    chk("start_one_cycle", eng_start, 0);
    wait_out_valid("j1_out_valid");
    chk("j1_gcd", out_gcd, 6);
    chk("j1_eng_a_held", eng_a, 48);
    step();
    chk("j1_valid_drop", out_valid, 0);
    chk("j1_gcd_zero", out_gcd, 0);
    wait_idle("j1_idle");
    chk("j1_starts", n_starts - s0, 1);
    chk("j1_results", results.size(), 1);

    // Zero operands back-to-back.
    s0 = n_starts; results.delete();
    in_valid = 1'b1; in_a = 16'd0; in_b = 16'd7;
    step();
    in_a = 16'd0; in_b = 16'd0;
    step();
    in_valid = 1'b0;
    wait_results("zero_count", 2);
    wait_idle("zero_idle");
    chk("zero_r0", results[0], 7);
    chk("zero_r1", results[1], 0);
    chk("zero_starts", n_starts - s0, 2);

    // Fill the queue while the consumer stalls.
    out_ready = 1'b0; s0 = n_starts; results.delete(); accepted = 0; ready6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) accepted++;
      if (i == 5) ready6 = in_ready;
      in_valid = 1'b1; in_a = ja[i]; in_b = jb[i];
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepted", accepted, 5);
    chk("fill_6th_blocked", ready6, 0);
    chk("fill_in_ready", in_ready, 0);
    wait_out_valid("stall_out_valid");
    chk("stall_gcd", out_gcd, 4);
    s1 = n_starts;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stall_valid_held", out_valid, 1);
      chk("stall_gcd_held", out_gcd, 4);
    end
    chk("stall_no_start", n_starts - s1, 0);
    chk("stall_eng_a", eng_a, 12);
    out_ready = 1'b1;
    wait_results("drain_count", 5);
    wait_idle("drain_idle");
    chk("drain_r0", results[0], 4);
    chk("drain_r1", results[1], 3);
    chk("drain_r2", results[2], 5);
    chk("drain_r3", results[3], 7);
    chk("drain_r4", results[4], 4);
    chk("drain_starts", n_starts - s0, 5);

    // Reset while waiting for the engine, with a second job queued.
    results.delete();
    in_valid = 1'b1; in_a = 16'd65535; in_b = 16'd1;
    step();
    in_a = 16'd3; in_b = 16'd3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && eng_start !== 1'b1; i++) step();
    chk("mid_issue_seen", eng_start, 1);
    step();
    chk("mid_wait_no_done", eng_done, 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_gcd", out_gcd, 0);
    rst_n = 1'b1;
    repeat (6) step();
    chk("mid_no_stale_result", results.size(), 0);
    chk("mid_still_idle", busy, 0);
    in_valid = 1'b1; in_a = 16'd12; in_b = 16'd4;
    step();
    in_valid = 1'b0;
    wait_results("post_rst_count", 1);
    chk("post_rst_gcd", results[0], 4);
    wait_idle("post_rst_idle");

`ifdef GCD_DISP_CYCLE_CNT_EN
    // Cycle count against the bench-measured ISSUE-to-done interval.
    meas_q.delete(); out_ready = 1'b0;
    chk("cyc_zero_idle", out_cycles, 0);
    in_valid = 1'b1; in_a = 16'd12; in_b = 16'd4;
    step();
    in_valid = 1'b0;
    wait_out_valid("cyc1_valid");
    chk("cyc1_gcd", out_gcd, 4);
    chk("cyc1_count", out_cycles, meas_q[meas_q.size()-1]);
    out_ready = 1'b1;
    step();
    chk("cyc1_zero_after", out_cycles, 0);
    wait_idle("cyc1_idle");
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'd65535; in_b = 16'd1;
    step();
    in_valid = 1'b0;
    wait_out_valid("cyc2_valid");
    chk("cyc2_gcd", out_gcd, 1);
    chk("cyc2_count", out_cycles, meas_q[meas_q.size()-1]);
    out_ready = 1'b1;
    wait_idle("cyc2_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
